mdio_phy_responder: RTL and testbench

MDIO_PHY_RESPONDER -- requirements
Module: mdio_phy_responder

---
 rtl/mdio_pkg.sv | 41 ++++
 rtl/mdio_phy_responder_if.sv | 21 ++
 rtl/mdio_edge_sync.sv | 32 +++
 rtl/mdio_phy_responder.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_mdio_phy_responder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO PHY responder.
// Holds frame FSM states, opcodes, register addresses and reset defaults.
package mdio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_OP,
        ST_PHYAD,
        ST_REGAD,
        ST_TA,
        ST_RD_DATA,
        ST_WR_DATA
    } state_e;

    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    localparam logic [4:0] REG_CTRL = 5'd0;
    localparam logic [4:0] REG_STAT = 5'd1;
    localparam logic [4:0] REG_ID1  = 5'd2;
    localparam logic [4:0] REG_ID2  = 5'd3;
    localparam logic [4:0] REG_ANAR = 5'd4;
    localparam logic [4:0] REG_R5   = 5'd5;
    localparam logic [4:0] REG_R6   = 5'd6;
    localparam logic [4:0] REG_R7   = 5'd7;

    localparam logic [15:0] CTRL_DEF = 16'h1140;
    localparam logic [15:0] STAT_DEF = 16'h796D;
    localparam logic [15:0] ANAR_DEF = 16'h01E1;
    localparam logic [15:0] RX_DEF   = 16'h0000;

    localparam logic [5:0] PRE_LEN   = 6'd32;
    localparam logic [4:0] DATA_BITS = 5'd16;

    // Status word with the live link bit spliced into bit 2.
    function automatic logic [15:0] stat_word(input logic link);
        return {STAT_DEF[15:3], link, STAT_DEF[1:0]};
    endfunction

endpackage

// File: rtl/mdio_phy_responder_if.sv
// MDIO pin bundle between the MAC (master) and the PHY responder (slave).
interface mdio_phy_responder_if;
    logic mdc;
    logic mdio_in;
    logic mdio_out;
    logic mdio_oen;

    modport master (
        output mdc,
        output mdio_in,
        input  mdio_out,
        input  mdio_oen
    );

    modport slave (
        input  mdc,
        input  mdio_in,
        output mdio_out,
        output mdio_oen
    );
endinterface

// File: rtl/mdio_edge_sync.sv
// Brings MDC and MDIO into the system clock domain and flags MDC edges.
module mdio_edge_sync (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    mdio_phy_responder_if.slave  pins,
    output logic                 mdc_rise_o,
    output logic                 mdc_fall_o,
    output logic                 mdio_o
);

    logic [1:0] mdc_q;
    logic [1:0] mdio_q;
    logic       mdc_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mdc_q      <= 2'b11;
            mdio_q     <= 2'b11;
            mdc_prev_q <= 1'b1;
        end else begin
            mdc_q      <= {mdc_q[0], pins.mdc};
            mdio_q     <= {mdio_q[0], pins.mdio_in};
            mdc_prev_q <= mdc_q[1];
        end
    end

    // MDIO shares the MDC sync depth, so a detected rise sees aligned data.
    assign mdc_rise_o = mdc_q[1] & ~mdc_prev_q;
    assign mdc_fall_o = ~mdc_q[1] & mdc_prev_q;
    assign mdio_o     = mdio_q[1];

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO PHY responder: frame FSM, register file and line driver.
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd0,
    parameter logic [15:0] PHY_ID1  = 16'h0141,
    parameter logic [15:0] PHY_ID2  = 16'h0DD1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic        link_up,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data
);

    mdio_phy_responder_if pins ();

    logic rise;
    logic fall;
    logic bit_s;

    state_e      state_q, state_d;
    logic [5:0]  pre_q,   pre_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [1:0]  op_q,    op_d;
    logic [4:0]  phy_q,   phy_d;
    logic [4:0]  rad_q,   rad_d;
    logic [15:0] sh_q,    sh_d;
    logic        out_q,   out_d;
    logic        oen_q,   oen_d;
    logic        stb_q,   stb_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] ctrl_q,  ctrl_d;
    logic [15:0] anar_q,  anar_d;
    logic [15:0] r5_q,    r5_d;
    logic [15:0] r6_q,    r6_d;
    logic [15:0] r7_q,    r7_d;

    logic [4:0]  rad_nxt;
    logic [15:0] wword;
    logic [15:0] rd_word;

    assign pins.mdc      = mdc;
    assign pins.mdio_in  = mdio_in;
    assign pins.mdio_out = out_q;
    assign pins.mdio_oen = oen_q;

    assign mdio_out  = pins.mdio_out;
    assign mdio_oen  = pins.mdio_oen;
    assign wr_strobe = stb_q;
    assign wr_addr   = waddr_q;
    assign wr_data   = wdata_q;

    mdio_edge_sync u_sync (
        .clk_i      (clk_clk),
        .rst_ni     (reset_reset_n),
        .pins       (pins),
        .mdc_rise_o (rise),
        .mdc_fall_o (fall),
        .mdio_o     (bit_s)
    );

    assign rad_nxt = {rad_q[3:0], bit_s};
    assign wword   = {sh_q[14:0], bit_s};

    // Snapshot source for the read path, addressed by the completing REGAD.
    always_comb begin
        rd_word = '0;
        unique case (rad_nxt)
            REG_CTRL: rd_word = ctrl_q;
            REG_STAT: rd_word = stat_word(link_up);
            REG_ID1:  rd_word = PHY_ID1;
            REG_ID2:  rd_word = PHY_ID2;
            REG_ANAR: rd_word = anar_q;
            REG_R5:   rd_word = r5_q;
            REG_R6:   rd_word = r6_q;
            REG_R7:   rd_word = r7_q;
            default:  rd_word = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        phy_d   = phy_q;
        rad_d   = rad_q;
        sh_d    = sh_q;
        out_d   = out_q;
        oen_d   = oen_q;
        stb_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        ctrl_d  = ctrl_q;
        anar_d  = anar_q;
        r5_d    = r5_q;
        r6_d    = r6_q;
        r7_d    = r7_q;

        // Preamble only accumulates while idle, so a new frame starts clean.
        if (state_q != ST_IDLE) begin
            pre_d = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    if (bit_s) begin
                        if (pre_q != PRE_LEN) begin
                            pre_d = pre_q + 6'd1;
                        end
                    end else begin
                        pre_d = '0;
                        if (pre_q == PRE_LEN) begin
                            state_d = ST_START;
                        end
                    end
                end
            end
            ST_START: begin
                if (rise) begin
                    cnt_d   = '0;
                    state_d = bit_s ? ST_OP : ST_IDLE;
                end
            end
            ST_OP: begin
                if (rise) begin
                    op_d = {op_q[0], bit_s};
                    if (cnt_q == 5'd1) begin
                        cnt_d = '0;
                        if (op_d == OP_RD || op_d == OP_WR) begin
                            state_d = ST_PHYAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_PHYAD: begin
                if (rise) begin
                    phy_d = {phy_q[3:0], bit_s};
                    if (cnt_q == 5'd4) begin
                        cnt_d   = '0;
                        state_d = ST_REGAD;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_REGAD: begin
                if (rise) begin
                    rad_d = rad_nxt;
                    if (cnt_q == 5'd4) begin
                        cnt_d = '0;
                        if (phy_q != PHY_ADDR) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_TA;
                            sh_d    = rd_word;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_TA: begin
                // Reads take the line on the fall after the first TA sample.
                unique case (1'b1)
                    rise: begin
                        if (op_q == OP_WR && cnt_q == 5'd1) begin
                            cnt_d   = '0;
                            state_d = ST_WR_DATA;
                        end else begin
                            cnt_d = 5'd1;
                        end
                    end
                    fall: begin
                        if (op_q == OP_RD && cnt_q != 5'd0) begin
                            oen_d   = 1'b0;
                            out_d   = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
            ST_RD_DATA: begin
                if (fall) begin
                    if (cnt_q == DATA_BITS) begin
                        oen_d   = 1'b1;
                        out_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        out_d = sh_q[15];
                        sh_d  = {sh_q[14:0], 1'b0};
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_WR_DATA: begin
                if (rise) begin
                    sh_d = wword;
                    if (cnt_q == DATA_BITS - 5'd1) begin
                        state_d = ST_IDLE;
                        stb_d   = 1'b1;
                        waddr_d = rad_q;
                        wdata_d = wword;
                        unique case (rad_q)
                            REG_CTRL: begin
                                if (wword[15]) begin
                                    ctrl_d = CTRL_DEF;
                                    anar_d = ANAR_DEF;
                                    r5_d   = RX_DEF;
                                    r6_d   = RX_DEF;
                                    r7_d   = RX_DEF;
                                end else begin
                                    ctrl_d = wword;
                                end
                            end
                            REG_ANAR: anar_d = wword;
                            REG_R5:   r5_d   = wword;
                            REG_R6:   r6_d   = wword;
                            REG_R7:   r7_d   = wword;
                            default:  ;
                        endcase
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            phy_q   <= '0;
            rad_q   <= '0;
            sh_q    <= '0;
            out_q   <= 1'b1;
            oen_q   <= 1'b1;
            stb_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ctrl_q  <= CTRL_DEF;
            anar_q  <= ANAR_DEF;
            r5_q    <= RX_DEF;
            r6_q    <= RX_DEF;
            r7_q    <= RX_DEF;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            phy_q   <= phy_d;
            rad_q   <= rad_d;
            sh_q    <= sh_d;
            out_q   <= out_d;
            oen_q   <= oen_d;
            stb_q   <= stb_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            anar_q  <= anar_d;
            r5_q    <= r5_d;
            r6_q    <= r6_d;
            r7_q    <= r7_d;
        end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed MAC-side bench for mdio_phy_responder.
module tb_mdio_phy_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        link_up;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int n_cmp = 0;
    int n_bad = 0;
    int stb_cnt = 0;
    int drv_cnt = 0;

    mdio_phy_responder_if mac ();

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_strobe) stb_cnt <= stb_cnt + 1;
        if (!mac.mdio_oen) drv_cnt <= drv_cnt + 1;
    end

    mdio_phy_responder #(
        .PHY_ADDR (5'd0),
        .PHY_ID1  (16'h0141),
        .PHY_ID2  (16'h0DD1)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .mdc           (mac.mdc),
        .mdio_in       (mac.mdio_in),
        .mdio_out      (mac.mdio_out),
        .mdio_oen      (mac.mdio_oen),
        .link_up       (link_up),
        .wr_strobe     (wr_strobe),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data)
    );

    // One MDC period: MAC changes data while MDC is low, samples at the rise.
    task automatic mbit(input logic b, output logic o, output logic e);
        mac.mdc = 1'b0;
        mac.mdio_in = b;
        repeat (8) @(negedge clk);
        mac.mdc = 1'b1;
        o = mac.mdio_out;
        e = mac.mdio_oen;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_hdr(input int npre, input logic [1:0] op,
                            input logic [4:0] pa, input logic [4:0] ra);
        logic o, e;
        logic [13:0] hdr;
        hdr = {2'b01, op, pa, ra};
        mbit(1'b0, o, e);
        repeat (npre) mbit(1'b1, o, e);
        for (int i = 13; i >= 0; i--) mbit(hdr[i], o, e);
    endtask

    task automatic frame(input int npre, input logic [1:0] op,
                         input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, output logic [15:0] rd,
                         output logic [1:0] ta_oen, output logic ta_out,
                         output logic drv_all, output logic rel_oen);
        logic o, e;
        send_hdr(npre, op, pa, ra);
        rd = '0;
        drv_all = 1'b1;
        ta_oen = '0;
        ta_out = 1'b1;
        if (op == 2'b10) begin
            mbit(1'b1, o, e);
            ta_oen[1] = e;
            mbit(1'b1, o, e);
            ta_oen[0] = e;
            ta_out = o;
            for (int i = 15; i >= 0; i--) begin
                mbit(1'b1, o, e);
                rd[i] = o;
                if (e) drv_all = 1'b0;
            end
        end else begin
            mbit(1'b1, o, e);
            mbit(1'b0, o, e);
            for (int i = 15; i >= 0; i--) mbit(wd[i], o, e);
        end
        mbit(1'b1, o, e);
        rel_oen = e;
    endtask

    task automatic rd_reg(input logic [4:0] pa, input logic [4:0] ra,
                          output logic [15:0] rd);
        logic [1:0] t;
        logic to, da, rl;
        frame(32, 2'b10, pa, ra, 16'h0, rd, t, to, da, rl);
    endtask

    task automatic wr_reg(input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd);
        logic [15:0] rd;
        logic [1:0] t;
        logic to, da, rl;
        frame(32, 2'b01, pa, ra, wd, rd, t, to, da, rl);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        link_up = 1'b1;
        mac.mdc = 1'b1;
        mac.mdio_in = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({mac.mdio_oen, mac.mdio_out} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_line: got oen/out=%b want 11",
                     {mac.mdio_oen, mac.mdio_out});
        end
        n_cmp++;
        if ({wr_strobe, wr_addr, wr_data} !== 22'h0) begin
            n_bad++;
            $display("FAIL reset_wr: got stb=%b addr=%h data=%h want 0",
                     wr_strobe, wr_addr, wr_data);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read_id;
        logic [15:0] rd;
        logic [1:0] t;
        logic to, da, rl;
        frame(32, 2'b10, 5'd0, 5'd2, 16'h0, rd, t, to, da, rl);
        n_cmp++;
        if (t !== 2'b10) begin
            n_bad++;
            $display("FAIL ta_oen: got %b want 10", t);
        end
        n_cmp++;
        if (to !== 1'b0) begin
            n_bad++;
            $display("FAIL ta_out: got %b want 0", to);
        end
        n_cmp++;
        if (rd !== 16'h0141 || da !== 1'b1) begin
            n_bad++;
            $display("FAIL id1: got %h drv=%b want 0141 drv=1", rd, da);
        end
        n_cmp++;
        if (rl !== 1'b1) begin
            n_bad++;
            $display("FAIL release: got oen=%b want 1", rl);
        end
        rd_reg(5'd0, 5'd3, rd);
        n_cmp++;
        if (rd !== 16'h0DD1) begin
            n_bad++;
            $display("FAIL id2: got %h want 0DD1", rd);
        end
    endtask

    task automatic test_write_readback;
        logic [15:0] rd;
        int s0;
        s0 = stb_cnt;
        wr_reg(5'd0, 5'd4, 16'hA5A5);
        n_cmp++;
        if (stb_cnt - s0 != 1) begin
            n_bad++;
            $display("FAIL wr_pulse: got %0d cycles want 1", stb_cnt - s0);
        end
        n_cmp++;
        if (wr_addr !== 5'd4 || wr_data !== 16'hA5A5) begin
            n_bad++;
            $display("FAIL wr_bus: got %h/%h want 04/a5a5", wr_addr, wr_data);
        end
        rd_reg(5'd0, 5'd4, rd);
        n_cmp++;
        if (rd !== 16'hA5A5) begin
            n_bad++;
            $display("FAIL rb_anar: got %h want a5a5", rd);
        end
    endtask

    task automatic test_phy_mismatch;
        logic [15:0] rd;
        int s0, d0;
        s0 = stb_cnt;
        d0 = drv_cnt;
        rd_reg(5'd3, 5'd2, rd);
        wr_reg(5'd3, 5'd4, 16'h0000);
        n_cmp++;
        if (drv_cnt != d0) begin
            n_bad++;
            $display("FAIL phy_drive: got %0d drive cycles want 0", drv_cnt - d0);
        end
        n_cmp++;
        if (stb_cnt != s0) begin
            n_bad++;
            $display("FAIL phy_strobe: got %0d want 0", stb_cnt - s0);
        end
        rd_reg(5'd0, 5'd4, rd);
        n_cmp++;
        if (rd !== 16'hA5A5) begin
            n_bad++;
            $display("FAIL phy_reg4: got %h want a5a5", rd);
        end
    endtask

    task automatic test_preamble;
        logic [15:0] rd;
        logic [1:0] t;
        logic to, da, rl;
        int d0;
        d0 = drv_cnt;
        frame(31, 2'b10, 5'd0, 5'd0, 16'h0, rd, t, to, da, rl);
        n_cmp++;
        if (drv_cnt != d0) begin
            n_bad++;
            $display("FAIL pre31: got %0d drive cycles want 0", drv_cnt - d0);
        end
        frame(32, 2'b10, 5'd0, 5'd0, 16'h0, rd, t, to, da, rl);
        n_cmp++;
        if (rd !== 16'h1140 || da !== 1'b1) begin
            n_bad++;
            $display("FAIL pre32: got %h drv=%b want 1140 drv=1", rd, da);
        end
    endtask

    task automatic test_status;
        logic [15:0] rd;
        link_up = 1'b1;
        rd_reg(5'd0, 5'd1, rd);
        n_cmp++;
        if (rd !== 16'h796D) begin
            n_bad++;
            $display("FAIL stat_up: got %h want 796d", rd);
        end
        link_up = 1'b0;
        rd_reg(5'd0, 5'd1, rd);
        n_cmp++;
        if (rd !== 16'h7969) begin
            n_bad++;
            $display("FAIL stat_dn: got %h want 7969", rd);
        end
        link_up = 1'b1;
    endtask

    task automatic test_unmapped;
        logic [15:0] rd;
        int s0;
        s0 = stb_cnt;
        wr_reg(5'd0, 5'd9, 16'hFFFF);
        n_cmp++;
        if (stb_cnt - s0 != 1 || wr_addr !== 5'd9 || wr_data !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL unm_wr: got n=%0d %h/%h want 1 09/ffff",
                     stb_cnt - s0, wr_addr, wr_data);
        end
        rd_reg(5'd0, 5'd9, rd);
        n_cmp++;
        if (rd !== 16'h0000) begin
            n_bad++;
            $display("FAIL unm_rd: got %h want 0000", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] rd;
        int s0;
        s0 = stb_cnt;
        wr_reg(5'd0, 5'd0, 16'h0100);
        wr_reg(5'd0, 5'd4, 16'h1234);
        wr_reg(5'd0, 5'd6, 16'hBEEF);
        n_cmp++;
        if (stb_cnt - s0 != 3) begin
            n_bad++;
            $display("FAIL b2b_pulses: got %0d want 3", stb_cnt - s0);
        end
        rd_reg(5'd0, 5'd0, rd);
        n_cmp++;
        if (rd !== 16'h0100) begin
            n_bad++;
            $display("FAIL b2b_ctrl: got %h want 0100", rd);
        end
        rd_reg(5'd0, 5'd4, rd);
        n_cmp++;
        if (rd !== 16'h1234) begin
            n_bad++;
            $display("FAIL b2b_anar: got %h want 1234", rd);
        end
    endtask

    task automatic test_soft_reset;
        logic [15:0] rd;
        wr_reg(5'd0, 5'd0, 16'h8000);
        n_cmp++;
        if (wr_addr !== 5'd0 || wr_data !== 16'h8000) begin
            n_bad++;
            $display("FAIL sr_bus: got %h/%h want 00/8000", wr_addr, wr_data);
        end
        rd_reg(5'd0, 5'd4, rd);
        n_cmp++;
        if (rd !== 16'h01E1) begin
            n_bad++;
            $display("FAIL sr_anar: got %h want 01e1", rd);
        end
        rd_reg(5'd0, 5'd0, rd);
        n_cmp++;
        if (rd !== 16'h1140) begin
            n_bad++;
            $display("FAIL sr_ctrl: got %h want 1140", rd);
        end
        rd_reg(5'd0, 5'd6, rd);
        n_cmp++;
        if (rd !== 16'h0000) begin
            n_bad++;
            $display("FAIL sr_r6: got %h want 0000", rd);
        end
    endtask

    task automatic test_reset_mid_read;
        logic [15:0] rd;
        logic [1:0] t;
        logic o, e, to, da, rl;
        wr_reg(5'd0, 5'd5, 16'hBEEF);
        send_hdr(32, 2'b10, 5'd0, 5'd5);
        mbit(1'b1, o, e);
        mbit(1'b1, o, e);
        for (int i = 0; i < 8; i++) mbit(1'b1, o, e);
        mac.mdc = 1'b0;
        mac.mdio_in = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (mac.mdio_oen !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_drive: got oen=%b want 0", mac.mdio_oen);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mac.mdio_oen, mac.mdio_out} !== 2'b11) begin
            n_bad++;
            $display("FAIL mid_release: got oen/out=%b want 11",
                     {mac.mdio_oen, mac.mdio_out});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mac.mdc = 1'b1;
        repeat (20) @(negedge clk);
        frame(32, 2'b10, 5'd0, 5'd5, 16'h0, rd, t, to, da, rl);
        n_cmp++;
        if (rd !== 16'h0000 || t !== 2'b10 || da !== 1'b1 || rl !== 1'b1) begin
            n_bad++;
            $display("FAIL post_rst: got %h ta=%b drv=%b rel=%b want 0000 10 1 1",
                     rd, t, da, rl);
        end
        rd_reg(5'd0, 5'd2, rd);
        n_cmp++;
        if (rd !== 16'h0141) begin
            n_bad++;
            $display("FAIL post_rst_id: got %h want 0141", rd);
        end
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_write_readback();
        test_phy_mismatch();
        test_preamble();
        test_status();
        test_unmapped();
        test_back_to_back();
        test_soft_reset();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
